tmds_word_aligner: RTL

// - Sits between the 1:10 deserializer and the TERC4/TMDS decoders on one HDMI/DVI channel.
// - Hunts for 10-bit word alignment by watching for TMDS control tokens.
// - Pulses bitslip to the deserializer until a run of control tokens is seen, then reports lock.
// - Registers the deserialized word out to the downstream decoders.

---
 rtl/tmds_word_aligner.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/tmds_word_aligner.sv
// TMDS word aligner for one HDMI/DVI channel.
// Hunts for 10-bit word alignment by counting runs of TMDS control tokens,
// pulsing bitslip to the deserializer until a run is found, then holds lock
// until control tokens go missing for too long.
// Optional statistics outputs are enabled with the macro ALIGN_STATS_EN.
module tmds_word_aligner #(
  parameter int unsigned CTRL_RUN      = 8,
  parameter int unsigned SEARCH_WINDOW = 2048,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned LOSS_WINDOW   = 4096
) (
  input  logic        clk_1x_in,
  input  logic        rst_in,
  input  logic [9:0]  deser_data,
  output logic [9:0]  data_out,
  output logic        ctrl_token,
  output logic        bitslip,
  output logic        aligned,
  output logic [3:0]  slip_pos
`ifdef ALIGN_STATS_EN
  ,
  output logic [15:0] slip_count,
  output logic [7:0]  lock_loss
`endif
);

  localparam int unsigned RUN_W    = $clog2(CTRL_RUN + 1);
  localparam int unsigned WIN_W    = $clog2(SEARCH_WINDOW + 1);
  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned GAP_W    = $clog2(LOSS_WINDOW + 1);

  localparam logic [9:0] TOKEN_0 = 10'b1101010100;
  localparam logic [9:0] TOKEN_1 = 10'b0010101011;
  localparam logic [9:0] TOKEN_2 = 10'b0101010100;
  localparam logic [9:0] TOKEN_3 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [RUN_W-1:0]    run_cnt, run_nxt;
  logic [WIN_W-1:0]    win_cnt, win_nxt;
  logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
  logic [GAP_W-1:0]    gap_cnt, gap_nxt;
  logic [3:0]          slip_pos_nxt;
  logic                is_token_c;
  logic                lock_lost_c;

  // Exact 10-bit match against the four control tokens on the raw word.
  always_comb begin
    is_token_c = (deser_data == TOKEN_0) || (deser_data == TOKEN_1) ||
                 (deser_data == TOKEN_2) || (deser_data == TOKEN_3);
  end

  // Registered datapath: word and token flag, one cycle of latency.
  always_ff @(posedge clk_1x_in or posedge rst_in) begin
    if (rst_in) begin
      data_out   <= '0;
      ctrl_token <= 1'b0;
    end else begin
      data_out   <= deser_data;
      ctrl_token <= is_token_c;
    end
  end

  // State, counters and registered control outputs.
  always_ff @(posedge clk_1x_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= ST_SEARCH;
      run_cnt    <= '0;
      win_cnt    <= '0;
      settle_cnt <= '0;
      gap_cnt    <= '0;
      slip_pos   <= '0;
      bitslip    <= 1'b0;
      aligned    <= 1'b0;
    end else begin
      state      <= state_nxt;
      run_cnt    <= run_nxt;
      win_cnt    <= win_nxt;
      settle_cnt <= settle_nxt;
      gap_cnt    <= gap_nxt;
      slip_pos   <= slip_pos_nxt;
      bitslip    <= (state_nxt == ST_SLIP);
      aligned    <= (state_nxt == ST_LOCKED);
    end
  end

  // Next-state and counter logic; detection works on the registered word.
  always_comb begin
    state_nxt    = state;
    run_nxt      = run_cnt;
    win_nxt      = win_cnt;
    settle_nxt   = settle_cnt;
    gap_nxt      = gap_cnt;
    slip_pos_nxt = slip_pos;
    lock_lost_c  = 1'b0;

    case (state)
      ST_SEARCH: begin
        if (run_cnt == RUN_W'(CTRL_RUN)) begin
          // Lock wins over a window expiry in the same cycle.
          state_nxt = ST_LOCKED;
          run_nxt   = '0;
          win_nxt   = '0;
          gap_nxt   = '0;
        end else if (win_cnt == WIN_W'(SEARCH_WINDOW - 1)) begin
          state_nxt    = ST_SLIP;
          run_nxt      = '0;
          win_nxt      = '0;
          slip_pos_nxt = (slip_pos == 4'd9) ? 4'd0 : slip_pos + 4'd1;
        end else begin
          win_nxt = win_cnt + WIN_W'(1);
          run_nxt = ctrl_token ? run_cnt + RUN_W'(1) : '0;
        end
      end

      ST_SLIP: begin
        state_nxt  = ST_SETTLE;
        settle_nxt = '0;
      end

      ST_SETTLE: begin
        // Deserializer output is unreliable right after a slip; tokens ignored.
        if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          state_nxt  = ST_SEARCH;
          settle_nxt = '0;
          win_nxt    = '0;
          run_nxt    = '0;
        end else begin
          settle_nxt = settle_cnt + SETTLE_W'(1);
        end
      end

      ST_LOCKED: begin
        if (gap_cnt == GAP_W'(LOSS_WINDOW - 1)) begin
          // Drop lock without slipping; the search resumes at the same position.
          state_nxt   = ST_SEARCH;
          gap_nxt     = '0;
          win_nxt     = '0;
          run_nxt     = '0;
          lock_lost_c = 1'b1;
        end else begin
          gap_nxt = ctrl_token ? '0 : gap_cnt + GAP_W'(1);
        end
      end

      default: begin
        state_nxt = ST_SEARCH;
      end
    endcase
  end

`ifdef ALIGN_STATS_EN
  // Saturating counts of bitslip pulses and lock losses since reset.
  always_ff @(posedge clk_1x_in or posedge rst_in) begin
    if (rst_in) begin
      slip_count <= '0;
      lock_loss  <= '0;
    end else begin
      if ((state_nxt == ST_SLIP) && (slip_count != 16'hFFFF)) begin
        slip_count <= slip_count + 16'd1;
      end
      if (lock_lost_c && (lock_loss != 8'hFF)) begin
        lock_loss <= lock_loss + 8'd1;
      end
    end
  end
`else
  // Loss strobe only feeds the statistics counters.
  logic unused_lock_lost;
  always_comb begin
    unused_lock_lost = lock_lost_c;
  end
`endif

endmodule
